// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard: tracks rd of the last DEPTH issued instructions,
// picks the youngest producer per source and raises load-use stalls.
// Optional perf counters: define FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SELW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_dec,
  input  logic            dec_valid,
  input  logic            stall_ext,
  input  logic            flush,
  output logic [SELW-1:0] rs1_fwd_sel,
  output logic [SELW-1:0] rs2_fwd_sel,
  output logic            stall_load_use
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]     perf_fwd_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [6:0]       opcode;
  logic [4:0]       rd, rs1, rs2;
  logic             writes_rd, reads_rs1, reads_rs2, is_load;
  logic [DEPTH-1:0] ent_valid, ent_load;
  logic [4:0]       ent_rd [DEPTH];
  logic [SELW-1:0]  rs1_sel, rs2_sel;
  logic             rs1_ld, rs2_ld, hazard;
  logic             unused_fields;

  assign opcode        = inst_dec[6:0];
  assign rd            = inst_dec[11:7];
  assign rs1           = inst_dec[19:15];
  assign rs2           = inst_dec[24:20];
  assign is_load       = (opcode == OP_LOAD);
  assign unused_fields = ^{inst_dec[31:25], inst_dec[14:12]};

  // Opcode classification; x0 destinations are never tracked
  always_comb begin : decode_class
    writes_rd = 1'b0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (opcode)
      OP_R:                    begin writes_rd = 1'b1; reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR: begin writes_rd = 1'b1; reads_rs1 = 1'b1; end
      OP_STORE, OP_BR:         begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      default:                 ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  // Oldest-to-youngest scan so the youngest match overwrites older ones
  always_comb begin : match_scan
    rs1_sel = '0;
    rs2_sel = '0;
    rs1_ld  = 1'b0;
    rs2_ld  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (dec_valid && reads_rs1 && (rs1 != 5'd0) && ent_valid[k-1] && (ent_rd[k-1] == rs1)) begin
        rs1_sel = SELW'(k);
        rs1_ld  = ent_load[k-1];
      end
      if (dec_valid && reads_rs2 && (rs2 != 5'd0) && ent_valid[k-1] && (ent_rd[k-1] == rs2)) begin
        rs2_sel = SELW'(k);
        rs2_ld  = ent_load[k-1];
      end
    end
  end

  assign hazard = (rs1_ld && (32'(rs1_sel) < LOAD_STAGE)) ||
                  (rs2_ld && (32'(rs2_sel) < LOAD_STAGE));
  assign stall_load_use = hazard & ~flush & ~stall_ext;
  assign rs1_fwd_sel    = stall_load_use ? '0 : rs1_sel;
  assign rs2_fwd_sel    = stall_load_use ? '0 : rs2_sel;

  // In-flight shift pipeline; index 0 is stage 1 (EX)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_valid <= '0;
    end else if (!stall_ext) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_rd[k]    <= ent_rd[k-1];
      end
      ent_valid[0] <= dec_valid & writes_rd & ~stall_load_use;
      ent_load[0]  <= is_load;
      ent_rd[0]    <= rd;
    end
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fwd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (dec_valid && !stall_ext && ((rs1_fwd_sel != '0) || (rs2_fwd_sel != '0)) &&
          (perf_fwd_cnt != 32'hFFFF_FFFF))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      if (stall_load_use && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (DEPTH=3, LOAD_STAGE=2); hand-computed expectations.
module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_dec;
  logic        dec_valid, stall_ext, flush;
  logic [1:0]  rs1_fwd_sel, rs2_fwd_sel;
  logic        stall_load_use;
`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] perf_fwd_cnt, perf_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  fwd_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .inst_dec       (inst_dec),
    .dec_valid      (dec_valid),
    .stall_ext      (stall_ext),
    .flush          (flush),
    .rs1_fwd_sel    (rs1_fwd_sel),
    .rs2_fwd_sel    (rs2_fwd_sel),
    .stall_load_use (stall_load_use)
`ifdef FWD_SCOREBOARD_PERF_EN
    ,
    .perf_fwd_cnt   (perf_fwd_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return {f7, b, a, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] a, input logic [11:0] imm);
    return {imm, a, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_op(input logic [4:0] b, input logic [4:0] a, input logic [11:0] imm);
    return {imm[11:5], b, a, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] e1, input logic [1:0] e2, input logic es);
    check({tag, ".rs1"}, 32'(rs1_fwd_sel), 32'(e1));
    check({tag, ".rs2"}, 32'(rs2_fwd_sel), 32'(e2));
    check({tag, ".stall"}, 32'(stall_load_use), 32'(es));
  endtask

  // Drive just after a rising edge, then settle before checking
  task automatic drive(input logic [31:0] inst, input logic v, input logic f,
                       input logic s, input logic r);
    inst_dec  = inst;
    dec_valid = v;
    flush     = f;
    stall_ext = s;
    rst       = r;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] add_x3, add_x5, sub_x6, addi_x12, or_x7, lw_x8, add_x9, addi_x0, add_x4;
  logic [31:0] sw0, sw10, add_x1_st, addi5_1, addi5_2, add_x1_55, lw_x8b, add_x2_99;

  initial begin
    add_x3    = r_op(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
    add_x5    = r_op(7'b0000000, 3'b000, 5'd5, 5'd1, 5'd2);
    sub_x6    = r_op(7'b0100000, 3'b000, 5'd6, 5'd5, 5'd5);
    addi_x12  = i_op(7'b0010011, 3'b000, 5'd12, 5'd0, 12'd0);
    or_x7     = r_op(7'b0000000, 3'b110, 5'd7, 5'd5, 5'd0);
    lw_x8     = i_op(7'b0000011, 3'b010, 5'd8, 5'd1, 12'd0);
    add_x9    = r_op(7'b0000000, 3'b000, 5'd9, 5'd8, 5'd1);
    addi_x0   = i_op(7'b0010011, 3'b000, 5'd0, 5'd0, 12'd1);
    add_x4    = r_op(7'b0000000, 3'b000, 5'd4, 5'd0, 5'd0);
    sw0       = s_op(5'd10, 5'd11, 12'd0);
    sw10      = s_op(5'd1, 5'd11, 12'd10);
    add_x1_st = r_op(7'b0000000, 3'b000, 5'd1, 5'd10, 5'd11);
    addi5_1   = i_op(7'b0010011, 3'b000, 5'd5, 5'd0, 12'd1);
    addi5_2   = i_op(7'b0010011, 3'b000, 5'd5, 5'd0, 12'd2);
    add_x1_55 = r_op(7'b0000000, 3'b000, 5'd1, 5'd5, 5'd5);
    lw_x8b    = i_op(7'b0000011, 3'b010, 5'd8, 5'd2, 12'd0);
    add_x2_99 = r_op(7'b0000000, 3'b000, 5'd2, 5'd9, 5'd9);

    drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick; tick;
    chk3("reset", 2'd0, 2'd0, 1'b0);
`ifdef FWD_SCOREBOARD_PERF_EN
    check("perf_fwd_rst", perf_fwd_cnt, 32'd0);
    check("perf_stall_rst", perf_stall_cnt, 32'd0);
`endif

    drive(add_x3, 1, 0, 0, 0);  chk3("add_x3", 0, 0, 0);           tick;
    drive(add_x5, 1, 0, 0, 0);  chk3("add_x5", 0, 0, 0);           tick;
    drive(sub_x6, 1, 0, 0, 0);  chk3("sub_x6", 1, 1, 0);           tick;
    drive(addi_x12, 1, 0, 0, 0); chk3("unrelated", 0, 0, 0);       tick;
    drive(or_x7, 1, 0, 0, 0);   chk3("or_x7_stage3", 3, 0, 0);     tick;

    // Load-use: one bubble, then forward from MEM
    drive(lw_x8, 1, 0, 0, 0);   chk3("lw_x8", 0, 0, 0);            tick;
    drive(add_x9, 1, 0, 0, 0);  chk3("lu_stall", 0, 0, 1);         tick;
    drive(add_x9, 1, 0, 0, 0);  chk3("lu_after", 2, 0, 0);         tick;

    // x0 and stores never produce a forward
    drive(addi_x0, 1, 0, 0, 0); chk3("addi_x0", 0, 0, 0);          tick;
    drive(add_x4, 1, 0, 0, 0);  chk3("add_x0_x0", 0, 0, 0);        tick;
    drive(sw0, 1, 0, 0, 0);     chk3("sw0", 0, 0, 0);              tick;
    drive(sw10, 1, 0, 0, 0);    chk3("sw10", 0, 0, 0);             tick;
    drive(add_x1_st, 1, 0, 0, 0); chk3("after_store", 0, 0, 0);    tick;

    // Youngest producer wins
    drive(addi5_1, 1, 0, 0, 0); tick;
    drive(addi5_2, 1, 0, 0, 0); tick;
    drive(add_x1_55, 1, 0, 0, 0); chk3("youngest", 1, 1, 0);       tick;

    // Flush squashes in-flight entries
    drive(addi5_1, 1, 0, 0, 0); tick;
    drive(addi5_2, 1, 0, 0, 0); tick;
    drive(add_x1_55, 1, 1, 0, 0); chk3("flush_cycle", 1, 1, 0);    tick;
    drive(add_x1_55, 1, 0, 0, 0); chk3("after_flush", 0, 0, 0);    tick;

    // External stall holds everything
    drive(addi5_1, 1, 0, 0, 0); tick;
    drive(addi5_2, 1, 0, 0, 0); tick;
    for (int i = 0; i < 4; i++) begin
      drive(add_x1_55, 1, 0, 1, 0); chk3("stall_ext_hold", 1, 1, 0); tick;
    end
    drive(add_x1_55, 1, 0, 0, 0); chk3("stall_ext_release", 1, 1, 0); tick;

    // Load-use masked by stall_ext, then taken
    drive(lw_x8b, 1, 0, 0, 0);  chk3("lw_x8b", 0, 0, 0);           tick;
    drive(add_x9, 1, 0, 1, 0);  chk3("lu_masked", 1, 2, 0);        tick;
    drive(add_x9, 1, 0, 0, 0);  chk3("lu_stall2", 0, 0, 1);        tick;
    drive(add_x9, 1, 0, 0, 0);  chk3("lu_after2", 2, 3, 0);        tick;

    // Reset in the middle of a load-use stall
    drive(lw_x8b, 1, 0, 0, 0);  tick;
    drive(add_x9, 1, 0, 0, 1);  chk3("lu_stall_rst", 0, 0, 1);
`ifdef FWD_SCOREBOARD_PERF_EN
    check("perf_fwd_cnt", perf_fwd_cnt, 32'd7);
    check("perf_stall_cnt", perf_stall_cnt, 32'd2);
`endif
    tick;
    drive(add_x9, 1, 0, 0, 0);  chk3("after_rst", 0, 0, 0);
`ifdef FWD_SCOREBOARD_PERF_EN
    check("perf_fwd_clr", perf_fwd_cnt, 32'd0);
    check("perf_stall_clr", perf_stall_cnt, 32'd0);
`endif
    tick;

    // dec_valid gates matching
    drive(add_x2_99, 0, 0, 0, 0); chk3("dec_invalid", 0, 0, 0);    tick;
    drive(add_x2_99, 1, 0, 0, 0); chk3("dec_valid", 2, 2, 0);      tick;
`ifdef FWD_SCOREBOARD_PERF_EN
    check("perf_fwd_one", perf_fwd_cnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised, stateful successor to the two-instruction forwarding check.
- Tracks destination registers of the last DEPTH issued RV32I instructions in an internal shift pipeline.
- For the instruction in decode, selects, per source operand, the youngest in-flight producer, or the register file when there is none.
- Detects load-use hazards and raises a stall while inserting a bubble.
- Sits between decode and the EX operand muxes.

Parameters:
- DEPTH, 3: number of in-flight stages tracked (stage 1 = EX, stage 2 = MEM, stage 3 = WB); legal range 1..7.
- LOAD_STAGE, 2: first stage at which load data can be forwarded; legal range 1..DEPTH.
- SELW, $clog2(DEPTH+1): width of the forward-select outputs (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_dec  in  32  instruction currently in decode.
- dec_valid  in  1  inst_dec is a real instruction (0 = bubble).
- stall_ext  in  1  external freeze (e.g. memory wait); scoreboard holds all state.
- flush  in  1  branch/jump redirect; all in-flight entries are squashed.
- rs1_fwd_sel  out  SELW  0 = register file; k = forward from stage k.
- rs2_fwd_sel  out  SELW  as rs1_fwd_sel, for rs2.
- stall_load_use  out  1  decode must hold; a bubble enters stage 1.

Behaviour:
- Entry per stage k = 1..DEPTH holds {valid, rd[4:0], is_load}.
- Decode classification by opcode inst_dec[6:0]:
  - Writes rd: R (0110011), IMM (0010011), LOAD (0000011), LUI, AUIPC, JAL, JALR, and only when rd != 0.
  - Reads rs1: R, IMM, LOAD, S, SB, JALR.
  - Reads rs2: R, S, SB.
  - Any other opcode, including 32'b0, reads and writes nothing.
- Entries are inserted with valid = dec_valid & writes_rd.
- Match on stage k: entry valid, source used, dec_valid, and entry.rd == source index. x0 never matches.
- Forward select:
  - rsN_fwd_sel is the smallest k (youngest) that matches; 0 if no stage matches.
  - Outputs are combinational from inst_dec and registered state; no added latency.
- Load-use hazard:
  - Raised if the youngest match for either source has is_load = 1 and k < LOAD_STAGE.
  - stall_load_use = hazard & ~flush & ~stall_ext.
  - While stall_load_use is asserted, both sel outputs read 0.
- Clock edge, evaluated in priority order:
  1. rst: all valid bits cleared.
  2. flush: all valid bits cleared; inst_dec is not inserted.
  3. stall_ext: all entries hold.
  4. stall_load_use: stages shift by one (k to k+1, stage DEPTH discarded); stage 1 receives an invalid bubble.
  5. Otherwise: stages shift and stage 1 receives the classified inst_dec.
- After reset: all entries invalid, both sel outputs 0, stall_load_use 0.
- Reset mid-stall clears the hazard on the next cycle.
- Same rd in several stages: the youngest wins.
- rs1 == rs2: both selects are identical.

Optional Feature:
- Macro FWD_SCOREBOARD_PERF_EN.
- When defined, adds outputs perf_fwd_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fwd_cnt increments once per cycle in which (rs1_fwd_sel != 0 or rs2_fwd_sel != 0), the cycle is not stall_ext, and dec_valid is set.
  - perf_stall_cnt increments per cycle with stall_load_use asserted.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When not defined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then inst_dec = add x3,x1,x2 with dec_valid=1 -> rs1_fwd_sel=0, rs2_fwd_sel=0, stall_load_use=0.
- Issue add x5,x1,x2, then sub x6,x5,x5 next cycle -> rs1_fwd_sel=1, rs2_fwd_sel=1. Issue an unrelated instruction, then or x7,x5,x0 -> rs1_fwd_sel=3, rs2_fwd_sel=0.
- Issue lw x8,0(x1), then add x9,x8,x1 -> stall_load_use=1 and sels 0 for one cycle. Next cycle, with the same inst_dec -> stall_load_use=0, rs1_fwd_sel=2.
- Issue addi x0,x0,1, then add x4,x0,x0 -> both sels 0. Issue sw x10,0(x11) (no rd), then add x1,x10,x11 -> no forward from the store's bits [11:7].
- Issue addi x5,x0,1, addi x5,x0,2, then add x1,x5,x5 -> sel=1 (youngest). Instead assert flush on the cycle after the second addi -> next cycle sel=0. Instead hold stall_ext=1 for 4 cycles -> selects unchanged throughout.
- With FWD_SCOREBOARD_PERF_EN defined, run the load-use and forward scenarios -> perf_stall_cnt=1, perf_fwd_cnt equals the count of forwarding cycles; rst clears both counters to 0.
